dst_stream_ctrl: RTL and testbench

//  Parametrised destination-side stream controller for the CGRA output path.

---
 rtl/dst_stream_ctrl.sv | 156 +++++++++++++++
 tb/tb_dst_stream_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_stream_ctrl.sv
// Destination-side stream controller: queues burst-completion pulses and replays each burst as
// local-buffer reads with a registered valid/last stage. Optional stall counter: DST_STREAM_PERF_EN.
module dst_stream_ctrl #(
  parameter int AW     = 5,
  parameter int PEND_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_len_m1,
  input  logic          s_fin_in,
  input  logic          dst_ready,
  output logic          stream_v,
  output logic [AW-1:0] stream_a,
  output logic          dst_valid,
  output logic          dst_last,
  output logic          busy,
  output logic          err_ovf
`ifdef DST_STREAM_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW-1:0]       len_q, len_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                consume;
  logic                active;
  logic                final_beat;

  assign active     = (state_q == S_ACTIVE);
  assign final_beat = (idx_q == len_q);
  assign stream_v   = active & dst_ready;
  assign stream_a   = base_q + idx_q;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    base_d  = base_q;
    len_d   = len_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    consume = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ACTIVE;
          base_d  = cfg_base;
          len_d   = cfg_len_m1;
          idx_d   = '0;
          consume = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (stream_v) begin
          if (!final_beat) begin
            idx_d = idx_q + AW'(1);
          end else if (pend_q != '0) begin
            // Next queued burst starts on the following cycle with no idle bubble.
            base_d  = cfg_base;
            len_d   = cfg_len_m1;
            idx_d   = '0;
            consume = 1'b1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({s_fin_in, consume})
      2'b10: begin
        if (pend_q == '1) err_d  = 1'b1;
        else              pend_d = pend_q + PEND_W'(1);
      end
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    if (dst_ready) begin
      valid_d = active;
      last_d  = active & final_beat;
    end

    // Soft clear wins over every event this cycle but keeps the sticky overflow flag.
    if (!run) begin
      state_d = S_IDLE;
      pend_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      err_d   = err_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign dst_valid = valid_q;
  assign dst_last  = last_q;
  assign err_ovf   = err_q;
  assign busy      = active | (pend_q != '0) | valid_q;

`ifdef DST_STREAM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (active && !dst_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dst_stream_ctrl.sv
// Scoreboard bench for dst_stream_ctrl: expected read addresses and last flags are queued when
// completion pulses are issued and popped as the DUT strobes stream_v / transfers dst beats.
module tb_dst_stream_ctrl;
  localparam int AW     = 5;
  localparam int PEND_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len_m1;
  logic          s_fin_in;
  logic          dst_ready;
  logic          stream_v;
  logic [AW-1:0] stream_a;
  logic          dst_valid;
  logic          dst_last;
  logic          busy;
  logic          err_ovf;
`ifdef DST_STREAM_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic          exp_last_q[$];
  logic [AW-1:0] mon_a;
  logic          mon_l;

  always #5 clk = ~clk;

  dst_stream_ctrl #(.AW(AW), .PEND_W(PEND_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .cfg_base  (cfg_base),
    .cfg_len_m1(cfg_len_m1),
    .s_fin_in  (s_fin_in),
    .dst_ready (dst_ready),
    .stream_v  (stream_v),
    .stream_a  (stream_a),
    .dst_valid (dst_valid),
    .dst_last  (dst_last),
    .busy      (busy),
    .err_ovf   (err_ovf)
`ifdef DST_STREAM_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Scoreboard: one address per read strobe, one last flag per dst handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (stream_v) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL sb_addr: got stream_a=%0d, required no read strobe", stream_a);
        end else begin
          mon_a = exp_addr_q.pop_front();
          if (stream_a !== mon_a) begin
            fails++;
            $display("FAIL sb_addr: got stream_a=%0d, required %0d", stream_a, mon_a);
          end
        end
      end
      if (dst_valid && dst_ready) begin
        tests++;
        if (exp_last_q.size() == 0) begin
          fails++;
          $display("FAIL sb_beat: got dst beat (last=%b), required no beat", dst_last);
        end else begin
          mon_l = exp_last_q.pop_front();
          if (dst_last !== mon_l) begin
            fails++;
            $display("FAIL sb_last: got dst_last=%b, required %b", dst_last, mon_l);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [AW-1:0] base, input logic [AW-1:0] len);
    logic [AW-1:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_last_q.push_back(i == int'(len));
    end
  endtask

  task automatic flush_sb();
    exp_addr_q.delete();
    exp_last_q.delete();
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      next_cycle();
      #2;
      if (!busy && exp_addr_q.size() == 0 && exp_last_q.size() == 0) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_drain: got busy=%b addr_left=%0d beats_left=%0d, required idle and empty",
               name, busy, exp_addr_q.size(), exp_last_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; s_fin_in = 1'b0; dst_ready = 1'b1;
    cfg_base = '0; cfg_len_m1 = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();
    #2;
    tests++;
    if ({stream_v, dst_valid, dst_last, busy, err_ovf} !== 5'b0) begin
      fails++;
      $display("FAIL reset: got v/valid/last/busy/err=%b%b%b%b%b, required 00000",
               stream_v, dst_valid, dst_last, busy, err_ovf);
    end
`ifdef DST_STREAM_PERF_EN
    tests++;
    if (stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_stall: got %0d, required 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_single();
    cfg_base = AW'(0); cfg_len_m1 = AW'(3);
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      s_fin_in = (k == 0);
      if (k == 0) push_burst(AW'(0), AW'(3));
      #2;
      tests++;
      if (stream_v !== (k >= 2 && k <= 5)) begin
        fails++;
        $display("FAIL t1_stream_v c%0d: got %b, required %b", k, stream_v, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        tests++;
        if (stream_a !== AW'(k - 2)) begin
          fails++;
          $display("FAIL t1_stream_a c%0d: got %0d, required %0d", k, stream_a, k - 2);
        end
      end
      tests++;
      if (dst_valid !== (k >= 3 && k <= 6)) begin
        fails++;
        $display("FAIL t1_valid c%0d: got %b, required %b", k, dst_valid, (k >= 3 && k <= 6));
      end
      tests++;
      if (dst_last !== (k == 6)) begin
        fails++;
        $display("FAIL t1_last c%0d: got %b, required %b", k, dst_last, (k == 6));
      end
      tests++;
      if (busy !== (k >= 1 && k <= 6)) begin
        fails++;
        $display("FAIL t1_busy c%0d: got %b, required %b", k, busy, (k >= 1 && k <= 6));
      end
    end
    wait_idle("t1");
  endtask

  task automatic test_back_to_back();
    cfg_base = AW'(4); cfg_len_m1 = AW'(3);
    for (int k = 0; k <= 12; k++) begin
      next_cycle();
      s_fin_in = (k <= 1);
      if (k <= 1) push_burst(AW'(4), AW'(3));
      #2;
      tests++;
      if (dst_valid !== (k >= 3 && k <= 10)) begin
        fails++;
        $display("FAIL t2_valid c%0d: got %b, required %b", k, dst_valid, (k >= 3 && k <= 10));
      end
      tests++;
      if (dst_last !== (k == 6 || k == 10)) begin
        fails++;
        $display("FAIL t2_last c%0d: got %b, required %b", k, dst_last, (k == 6 || k == 10));
      end
    end
    wait_idle("t2");
  endtask

  task automatic test_backpressure();
    cfg_base = AW'(10); cfg_len_m1 = AW'(3);
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      s_fin_in  = (k == 0);
      dst_ready = !(k == 3 || k == 4);
      if (k == 0) push_burst(AW'(10), AW'(3));
      #2;
      if (k == 3 || k == 4) begin
        tests++;
        if (stream_v !== 1'b0 || dst_valid !== 1'b1) begin
          fails++;
          $display("FAIL t3_stall c%0d: got stream_v=%b dst_valid=%b, required 0 1",
                   k, stream_v, dst_valid);
        end
      end
      if (k == 8 || k == 9) begin
        tests++;
        if ({dst_valid, dst_last} !== ((k == 8) ? 2'b11 : 2'b00)) begin
          fails++;
          $display("FAIL t3_tail c%0d: got valid/last=%b%b, required %b",
                   k, dst_valid, dst_last, (k == 8) ? 2'b11 : 2'b00);
        end
      end
    end
    dst_ready = 1'b1;
    wait_idle("t3");
`ifdef DST_STREAM_PERF_EN
    tests++;
    if (stall_cnt !== 32'd2) begin
      fails++;
      $display("FAIL t3_stall_cnt: got %0d, required 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    cfg_base = AW'(30); cfg_len_m1 = AW'(3);
    next_cycle();
    s_fin_in = 1'b1;
    push_burst(AW'(30), AW'(3));
    next_cycle();
    s_fin_in = 1'b0;
    wait_idle("t4");
  endtask

  task automatic test_overflow();
    cfg_base = AW'(8); cfg_len_m1 = AW'(1);
    dst_ready = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      next_cycle();
      s_fin_in = (k <= 4);
      // Only four bursts fit: one in flight plus three queued.
      if (k <= 3) push_burst(AW'(8), AW'(1));
      #2;
      if (k == 4 || k == 5) begin
        tests++;
        if (err_ovf !== (k == 5)) begin
          fails++;
          $display("FAIL t5_err c%0d: got %b, required %b", k, err_ovf, (k == 5));
        end
      end
    end
    dst_ready = 1'b1;
    wait_idle("t5");
    tests++;
    if (err_ovf !== 1'b1) begin
      fails++;
      $display("FAIL t5_err_sticky: got %b, required 1", err_ovf);
    end
  endtask

  task automatic test_soft_clear();
    cfg_base = AW'(0); cfg_len_m1 = AW'(7);
    for (int k = 0; k <= 6; k++) begin
      next_cycle();
      s_fin_in = (k <= 1);
      run      = (k != 4);
      if (k <= 1) push_burst(AW'(0), AW'(7));
      #2;
      if (k == 5 || k == 6) begin
        tests++;
        if ({stream_v, dst_valid, dst_last, busy, err_ovf} !== 5'b00001) begin
          fails++;
          $display("FAIL t6_run c%0d: got v/valid/last/busy/err=%b%b%b%b%b, required 00001",
                   k, stream_v, dst_valid, dst_last, busy, err_ovf);
        end
      end
    end
    flush_sb();
  endtask

  task automatic test_async_reset();
    cfg_base = AW'(2); cfg_len_m1 = AW'(7);
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      s_fin_in = (k == 0);
      if (k == 0) push_burst(AW'(2), AW'(7));
    end
    #2;
    tests++;
    if (dst_valid !== 1'b1) begin
      fails++;
      $display("FAIL t6_pre_rst: got dst_valid=%b, required 1", dst_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({stream_v, dst_valid, dst_last, busy, err_ovf} !== 5'b0) begin
      fails++;
      $display("FAIL t6_async_rst: got v/valid/last/busy/err=%b%b%b%b%b, required 00000",
               stream_v, dst_valid, dst_last, busy, err_ovf);
    end
`ifdef DST_STREAM_PERF_EN
    tests++;
    if (stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL t6_rst_stall: got %0d, required 0", stall_cnt);
    end
`endif
    flush_sb();
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_soft_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
